// File: rtl/nios2_cpu_div_cell.sv
// nios2_cpu_div_cell: iterative restoring radix-2 divider for div/divu, start/busy/done handshake.
// Optional build macro NIOS2_DIV_SIGNED_EN enables two's-complement (div) support.
`default_nettype none

module nios2_cpu_div_cell #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] E_src1,
  input  logic [DATA_W-1:0] E_src2,
  input  logic              E_div_start,
  input  logic              E_div_signed,
  input  logic              M_kill,
  output logic [DATA_W-1:0] M_div_quotient,
  output logic [DATA_W-1:0] M_div_remainder,
  output logic              M_div_by_zero,
  output logic              M_div_busy,
  output logic              M_div_done
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] dvd;
  logic [DATA_W-1:0] dvs;
  logic [CNT_W-1:0]  count;
  logic              zero;
  logic [DATA_W-1:0] mag1, mag2;
  logic [DATA_W-1:0] q_fix, r_fix;
  logic [DATA_W+1:0] trial;
  logic              fits;
  logic              accept;

  assign accept = E_div_start && !M_kill;

`ifdef NIOS2_DIV_SIGNED_EN
  logic neg_q, neg_r;

  assign mag1  = (E_div_signed && E_src1[DATA_W-1]) ? -E_src1 : E_src1;
  assign mag2  = (E_div_signed && E_src2[DATA_W-1]) ? -E_src2 : E_src2;
  assign q_fix = neg_q ? -dvd : dvd;
  assign r_fix = neg_r ? -rem : rem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && accept) begin
      neg_q <= E_div_signed && (E_src1[DATA_W-1] ^ E_src2[DATA_W-1]);
      neg_r <= E_div_signed && E_src1[DATA_W-1];
    end
  end
`else
  logic unused_signed;
  assign unused_signed = E_div_signed;
  assign mag1  = E_src1;
  assign mag2  = E_src2;
  assign q_fix = dvd;
  assign r_fix = rem;
`endif

  // Shifted partial remainder needs DATA_W+1 bits; one more bit holds the borrow.
  assign trial = {1'b0, rem, dvd[DATA_W-1]} - {2'b00, dvs};
  assign fits  = ~trial[DATA_W+1];

  assign M_div_busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: begin
        if (M_kill)           state_nxt = IDLE;
        else if (count == '0) state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem             <= '0;
      dvd             <= '0;
      dvs             <= '0;
      count           <= '0;
      zero            <= 1'b0;
      M_div_quotient  <= '0;
      M_div_remainder <= '0;
      M_div_by_zero   <= 1'b0;
      M_div_done      <= 1'b0;
    end else begin
      M_div_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            dvd   <= mag1;
            dvs   <= mag2;
            rem   <= '0;
            count <= LAST;
            zero  <= (E_src2 == '0);
          end
        end
        CALC: begin
          if (!M_kill) begin
            rem   <= fits ? trial[DATA_W-1:0] : {rem[DATA_W-2:0], dvd[DATA_W-1]};
            dvd   <= {dvd[DATA_W-2:0], fits};
            count <= count - CNT_W'(1);
          end
        end
        FIX: begin
          if (!M_kill) begin
            // With a zero divisor every trial fits, so rem already equals |src1|.
            M_div_quotient  <= zero ? '1 : q_fix;
            M_div_remainder <= r_fix;
            M_div_by_zero   <= zero;
            M_div_done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nios2_cpu_div_cell.sv
// Self-checking bench for nios2_cpu_div_cell: arithmetic reference model plus directed vectors.
`default_nettype none

module tb_nios2_cpu_div_cell;

`ifdef NIOS2_DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] src1 = '0, src2 = '0;
  logic        start = 1'b0, sgn = 1'b0, kill = 1'b0;
  logic [31:0] quo, rmd;
  logic        dbz, busy, done;

  int total = 0;
  int bad   = 0;

  nios2_cpu_div_cell #(.DATA_W(32)) dut (
    .clk            (clk),
    .reset          (rst),
    .E_src1         (src1),
    .E_src2         (src2),
    .E_div_start    (start),
    .E_div_signed   (sgn),
    .M_kill         (kill),
    .M_div_quotient (quo),
    .M_div_remainder(rmd),
    .M_div_by_zero  (dbz),
    .M_div_busy     (busy),
    .M_div_done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {by_zero, quotient, remainder} from plain arithmetic.
  function automatic logic [64:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit s);
    longint sa, sb, sq, sr;
    if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF, a};
    if (s && SIGNED_EN) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sq = sa / sb;
      sr = sa % sb;
      return {1'b0, sq[31:0], sr[31:0]};
    end
    return {1'b0, a / b, a % b};
  endfunction

  // Transaction-level model: an op occupies 33 edges after acceptance, then publishes.
  logic        m_active;
  int          m_cnt;
  logic [64:0] m_pend;
  logic [31:0] m_q, m_r;
  logic        m_z, m_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_cnt    <= 0;
      m_pend   <= '0;
      m_q      <= '0;
      m_r      <= '0;
      m_z      <= 1'b0;
      m_done   <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_active) begin
        if (kill) m_active <= 1'b0;
        else if (m_cnt == 32) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
          m_z      <= m_pend[64];
          m_q      <= m_pend[63:32];
          m_r      <= m_pend[31:0];
        end else m_cnt <= m_cnt + 1;
      end else if (start && !kill) begin
        m_active <= 1'b1;
        m_cnt    <= 0;
        m_pend   <= ref_div(src1, src2, sgn);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("busy", {31'd0, busy}, {31'd0, m_active});
      check("done", {31'd0, done}, {31'd0, m_done});
      check("quotient", quo, m_q);
      check("remainder", rmd, m_r);
      check("by_zero", {31'd0, dbz}, {31'd0, m_z});
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) break;
    end
  endtask

  task automatic pulse_start(input logic [31:0] a, input logic [31:0] b, input bit s);
    @(posedge clk); #1;
    src1 = a; src2 = b; sgn = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b, input bit s,
                        input logic [31:0] eq, input logic [31:0] er, input bit ez);
    int n;
    pulse_start(a, b, s);
    wait_done(n);
    check({name, "_latency"}, n, 34);
    check({name, "_q"}, quo, eq);
    check({name, "_r"}, rmd, er);
    check({name, "_z"}, {31'd0, dbz}, {31'd0, ez});
  endtask

  task automatic idle_no_done(input string name, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    check(name, seen, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_q", quo, 32'd0);
    check("rst_r", rmd, 32'd0);
    check("rst_flags", {29'd0, dbz, busy, done}, 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run_op("udiv", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
    run_op("sdiv", 32'hFFFF_FFF9, 32'd2, 1'b1,
           SIGNED_EN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC,
           SIGNED_EN ? 32'hFFFF_FFFF : 32'h0000_0001, 1'b0);
    run_op("dbz_u", 32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    run_op("dbz_s", 32'h8765_4321, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h8765_4321, 1'b1);
    run_op("ovf_s", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
           SIGNED_EN ? 32'h8000_0000 : 32'h0000_0000,
           SIGNED_EN ? 32'h0000_0000 : 32'h8000_0000, 1'b0);
    run_op("ovf_u", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0);
    run_op("s_mixed", 32'd100, 32'hFFFF_FFF9, 1'b1,
           SIGNED_EN ? 32'hFFFF_FFF2 : 32'd0,
           SIGNED_EN ? 32'd2 : 32'd100, 1'b0);

    // Start while busy is dropped; first operation completes on schedule.
    pulse_start(32'd1000, 32'd10, 1'b0);
    repeat (4) @(posedge clk);
    #1; src1 = 32'd5; src2 = 32'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(n);
    check("busy_start_latency", n, 34 - 5);
    check("busy_start_q", quo, 32'd100);
    check("busy_start_r", rmd, 32'd0);

    // Kill mid-calculation: busy drops next cycle, outputs keep the last result.
    pulse_start(32'd77, 32'd3, 1'b0);
    repeat (9) @(posedge clk);
    #1; kill = 1'b1;
    @(posedge clk); #1; kill = 1'b0;
    check("kill_busy", {31'd0, busy}, 32'd0);
    idle_no_done("kill_no_done", 40);
    check("kill_hold_q", quo, 32'd100);

    // Start and kill together in IDLE: nothing begins.
    @(posedge clk); #1;
    src1 = 32'd9; src2 = 32'd4; start = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    check("startkill_busy", {31'd0, busy}, 32'd0);
    idle_no_done("startkill_no_done", 40);

    // Back-to-back: start issued during the done cycle.
    pulse_start(32'd100, 32'd7, 1'b0);
    wait_done(n);
    check("b2b_first_latency", n, 34);
    src1 = 32'hFFFF_FFFF; src2 = 32'h10; sgn = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(n);
    check("b2b_second_latency", n, 34);
    check("b2b_q", quo, 32'h0FFF_FFFF);
    check("b2b_r", rmd, 32'h0000_000F);

    // Asynchronous reset mid-operation clears outputs immediately.
    pulse_start(32'd50, 32'd5, 1'b0);
    repeat (19) @(posedge clk);
    #2; rst = 1'b1;
    #1;
    check("arst_q", quo, 32'd0);
    check("arst_r", rmd, 32'd0);
    check("arst_flags", {29'd0, dbz, busy, done}, 32'd0);
    #1; rst = 1'b0;
    idle_no_done("arst_no_done", 40);

    run_op("post_rst", 32'd12345, 32'd100, 1'b0, 32'd123, 32'd45, 1'b0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
